mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between the IF-stage fetch and the MEM-stage load/store.
- Sequences each access with a request/ready handshake and returns a one-cycle ack to the winning requester.
- Produces stall_if and stall_mem so the pipeline freezes the PC, IF/ID and later stages while a requester waits. These stalls are combined with the load-use stall upstream of the PC and IF/ID write enables.
- Includes a timeout watchdog so a hung memory cannot lock the core.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_watchdog_counter.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        GID_IF = 1'b0,
        GID_DM = 1'b1
    } grant_id_e;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_watchdog_counter.sv
// Loadable up-counter that flags when an access has spent TIMEOUT cycles
// in its grant state; tc_o is high in the TIMEOUT-th counted cycle.
module watchdog_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at the terminal value so a lingering grant cannot wrap around.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between IF fetches and
// MEM loads/stores, with round-robin on contention and a timeout watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q;
    grant_id_e         last_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;

    logic busy;
    logic tc;
    logic done;
    logic timeoutHit;
    logic grantIf;
    logic grantDm;

    assign busy       = (state_q != IDLE);
    assign done       = busy && (mem_ready || tc);
    assign timeoutHit = busy && !mem_ready && tc;

    // The just-completed requester still has req high, so only the other side
    // may be granted on a completion edge.
    always_comb begin
        grantIf = 1'b0;
        grantDm = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req && dm_req) begin
                    if (last_q == GID_IF) grantDm = 1'b1;
                    else                  grantIf = 1'b1;
                end else if (if_req) begin
                    grantIf = 1'b1;
                end else if (dm_req) begin
                    grantDm = 1'b1;
                end
            end
            GNT_IF:  grantDm = done && dm_req;
            GNT_DM:  grantIf = done && if_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GID_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grantIf) begin
                state_q <= GNT_IF;
                last_q  <= GID_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                be_q    <= '1;
            end else if (grantDm) begin
                state_q <= GNT_DM;
                last_q  <= GID_DM;
                addr_q  <= dm_addr;
                we_q    <= dm_we;
                wdata_q <= dm_wdata;
                be_q    <= dm_be;
            end else if (done) begin
                state_q <= IDLE;
            end
            if (timeoutHit) begin
                err_q <= 1'b1;
            end
        end
    end

    watchdog_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(grantIf || grantDm),
        .inc_i (busy && !mem_ready),
        .tc_o  (tc)
    );

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign if_ack   = (state_q == GNT_IF) && done;
    assign dm_ack   = (state_q == GNT_DM) && done;
    assign if_rdata = ((state_q == GNT_IF) && mem_ready) ? mem_rdata : '0;
    assign dm_rdata = ((state_q == GNT_DM) && mem_ready) ? mem_rdata : '0;

    // Gated by rst_n so every output reads 0 while reset is asserted.
    assign stall_if  = rst_n && if_req && !if_ack;
    assign stall_mem = rst_n && dm_req && !dm_ack;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter: a reactive memory model with
// programmable wait states, requester tasks and an ack-driven checker.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_mem, err;

    int   checks = 0;
    int   errors = 0;
    int   waitCycles = 0;
    int   memCnt = 0;
    int   rdataLeak = 0;
    logic hang = 1'b0;

    typedef struct {
        logic        isDm;
        logic [31:0] addr;
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbQ[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .err      (err)
    );

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0F0F);
    endfunction

    // Memory model: ready after waitCycles stall cycles of a continuous request.
    always @(posedge clk) begin
        if (!mem_req || if_ack || dm_ack) memCnt <= 0;
        else                              memCnt <= memCnt + 1;
    end

    assign mem_ready = mem_req && !hang && (memCnt == waitCycles);
    assign mem_rdata = mem_ready ? memFn(mem_addr) : 32'hBAD0_BAD0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void pushExp(input logic isDm, input logic [31:0] addr, input logic we, input logic [31:0] rdata);
        exp_t e;
        e.isDm  = isDm;
        e.addr  = addr;
        e.we    = we;
        e.rdata = rdata;
        sbQ.push_back(e);
    endfunction

    // Every ack pops one expectation and checks source, address, direction and data.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (if_ack || dm_ack)) begin
            checkOutput("ack_exclusive", {1'b0, if_ack && dm_ack}, 2'b00);
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_ack", sbQ.size(), 1);
            end else begin
                e = sbQ.pop_front();
                checkOutput("ack_src", dm_ack, e.isDm);
                checkOutput("ack_addr", mem_addr, e.addr);
                checkOutput("ack_we", mem_we, e.we);
                checkOutput("ack_rdata", e.isDm ? dm_rdata : if_rdata, e.rdata);
                checkOutput("stall_vs_ack", e.isDm ? stall_mem : stall_if, 1'b0);
            end
        end
        if (rst_n && ((!if_ack && if_rdata != 32'h0) || (!dm_ack && dm_rdata != 32'h0))) begin
            rdataLeak++;
        end
    end

    // Drives one request, holds it until the ack, and reports cycles to ack,
    // stall cycles and cycles where the memory port showed this access.
    task automatic applyStimulus(input logic isDm, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output int cycles, output int stalls, output int holds);
        bit got;
        got    = 1'b0;
        cycles = 0;
        stalls = 0;
        holds  = 0;
        if (isDm) begin
            dm_we    = we;
            dm_addr  = addr;
            dm_wdata = wdata;
            dm_be    = be;
            dm_req   = 1'b1;
        end else begin
            if_addr = addr;
            if_req  = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (isDm ? stall_mem : stall_if) stalls++;
            if (mem_req && mem_addr == addr && mem_we == we &&
                (!we || (mem_wdata == wdata && mem_be == be))) holds++;
            if (isDm ? dm_ack : if_ack) got = 1'b1;
        end
        checkOutput(isDm ? "dm_ack_seen" : "if_ack_seen", got, 1'b1);
        @(posedge clk);
        #1;
        if (isDm) dm_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    initial begin
        int c, s, h, c2, s2, h2;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_be    = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset arriving in the middle of a hung fetch must drop everything at once.
        hang    = 1'b1;
        if_addr = 32'h0000_0080;
        if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_rst_mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_req", mem_req, 1'b0);
        checkOutput("midrst_if_ack", if_ack, 1'b0);
        checkOutput("midrst_stall_if", stall_if, 1'b0);
        checkOutput("midrst_stall_mem", stall_mem, 1'b0);
        checkOutput("midrst_err", err, 1'b0);
        #1;
        if_req = 1'b0;
        hang   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pushExp(1'b0, 32'h0000_0040, 1'b0, memFn(32'h0000_0040));
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        @(negedge clk);
        checkOutput("idle_mem_req", mem_req, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("fetch40_mem_req", mem_req, 1'b1);
        checkOutput("fetch40_mem_addr", mem_addr, 32'h0000_0040);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(posedge clk);
        #1;

        pushExp(1'b0, 32'h0000_0100, 1'b0, 32'h0050_0093);
        applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, c, s, h);
        checkOutput("fetch_cycles", c, 2);
        checkOutput("fetch_stall_cycles", s, 1);
        checkOutput("fetch_hold_cycles", h, 1);

        pushExp(1'b1, 32'h0000_2000, 1'b0, memFn(32'h0000_2000));
        pushExp(1'b0, 32'h0000_0300, 1'b0, memFn(32'h0000_0300));
        fork
            applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, c, s, h);
            applyStimulus(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, c2, s2, h2);
        join
        checkOutput("cont1_dm_cycles", c, 2);
        checkOutput("cont1_if_cycles_no_bubble", c2, 3);

        pushExp(1'b1, 32'h0000_2400, 1'b0, memFn(32'h0000_2400));
        applyStimulus(1'b1, 1'b0, 32'h0000_2400, 32'h0, 4'hF, c, s, h);

        pushExp(1'b0, 32'h0000_0500, 1'b0, memFn(32'h0000_0500));
        pushExp(1'b1, 32'h0000_2800, 1'b0, memFn(32'h0000_2800));
        fork
            applyStimulus(1'b1, 1'b0, 32'h0000_2800, 32'h0, 4'hF, c, s, h);
            applyStimulus(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, c2, s2, h2);
        join
        checkOutput("cont2_if_cycles", c2, 2);
        checkOutput("cont2_dm_cycles", c, 3);

        waitCycles = 3;
        pushExp(1'b1, 32'h0000_3000, 1'b1, memFn(32'h0000_3000));
        applyStimulus(1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b0011, c, s, h);
        checkOutput("store_cycles", c, 5);
        checkOutput("store_stall_cycles", s, 4);
        checkOutput("store_hold_cycles", h, 4);

        waitCycles = 14;
        pushExp(1'b0, 32'h0000_0600, 1'b0, memFn(32'h0000_0600));
        applyStimulus(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0, c, s, h);
        checkOutput("boundary_cycles", c, 16);
        checkOutput("boundary_err", err, 1'b0);
        waitCycles = 0;

        hang = 1'b1;
        pushExp(1'b0, 32'h0000_0700, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'h0, c, s, h);
        checkOutput("timeout_cycles", c, 16);
        checkOutput("timeout_err", err, 1'b1);
        hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("timeout_mem_req_dropped", mem_req, 1'b0);
        checkOutput("err_sticky", err, 1'b1);

        pushExp(1'b1, 32'h0000_2C00, 1'b0, memFn(32'h0000_2C00));
        applyStimulus(1'b1, 1'b0, 32'h0000_2C00, 32'h0, 4'hF, c, s, h);
        checkOutput("post_timeout_cycles", c, 2);
        checkOutput("post_timeout_err", err, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", sbQ.size(), 0);
        checkOutput("rdata_zero_without_ack", rdataLeak, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
